// File: rtl/aes_stream_feeder.sv
// aes_stream_feeder: packs four 32-bit words into an AES block, drives aes_cipher_top,
// and serialises the ciphertext back out as four 32-bit words.
module aes_stream_feeder #(
   parameter int TIMEOUT_CYC = 31
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] cfg_key,
   input  logic         cfg_key_we,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_data,
   output logic         m_last,
   output logic         aes_ld,
   output logic [127:0] aes_key,
   output logic [127:0] aes_text_in,
   input  logic         aes_done,
   input  logic [127:0] aes_text_out,
   output logic         busy,
   output logic [1:0]   err,
   input  logic         err_clr
);
   typedef enum logic [1:0] {COLLECT, LOAD, WAIT, DRAIN} state_t;
   state_t state, state_nxt;
   logic [1:0]   cnt;
   logic [7:0]   timer;
   logic [127:0] key_q, text_q, out_q;
   logic         s_hs, m_hs, tmo, key_drop;
   assign s_hs     = s_valid & s_ready;
   assign m_hs     = m_valid & m_ready;
   // done takes priority over the timeout in the same cycle
   assign tmo      = (state == WAIT) && !aes_done && (timer + 8'd1 == 8'(TIMEOUT_CYC));
   assign key_drop = cfg_key_we && (state == LOAD || state == WAIT);
   // ready is masked while reset is asserted so nothing is offered during reset
   assign s_ready     = rst && (state == COLLECT);
   assign m_valid     = (state == DRAIN);
   assign m_data      = out_q[127:96];
   assign m_last      = (state == DRAIN) && (cnt == 2'd3);
   assign aes_ld      = (state == LOAD);
   assign aes_key     = key_q;
   assign aes_text_in = text_q;
   assign busy        = (state != COLLECT);
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: state_nxt = (s_hs && cnt == 2'd3) ? LOAD : COLLECT;
         LOAD:    state_nxt = WAIT;
         WAIT:    state_nxt = aes_done ? DRAIN : (tmo ? COLLECT : WAIT);
         DRAIN:   state_nxt = (m_hs && cnt == 2'd3) ? COLLECT : DRAIN;
         default: state_nxt = COLLECT;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= COLLECT;
         cnt    <= '0;
         timer  <= '0;
         key_q  <= '0;
         text_q <= '0;
         out_q  <= '0;
         err    <= '0;
      end else begin
         state <= state_nxt;
         if ((s_hs && state == COLLECT) || (m_hs && state == DRAIN))
            cnt <= cnt + 2'd1;
         timer <= (state == WAIT) ? timer + 8'd1 : '0;
         if (cfg_key_we && (state == COLLECT || state == DRAIN))
            key_q <= cfg_key;
         if (s_hs)
            text_q <= {text_q[95:0], s_data};
         if (state == WAIT && aes_done)
            out_q <= aes_text_out;
         else if (m_hs)
            out_q <= {out_q[95:0], 32'd0};
         err <= (err_clr ? 2'b00 : err) | {key_drop, tmo};
      end
   end
endmodule

// File: doc/aes_stream_feeder.md
Name: aes_stream_feeder

Overview:
Word-stream front/back end for the aes_cipher_top core. Packs four 32-bit input words into one 128-bit plaintext block. Issues a single-cycle ld pulse to the core with the held key, then waits for done. Serialises the 128-bit ciphertext back out as four 32-bit words over a valid/ready stream. Sits directly between the system bus-side stream and aes_cipher_top; drives its ld/key/text_in and consumes its done/text_out.

Parameters:
TIMEOUT_CYC, 31, max cycles in WAIT before declaring the core hung (valid range 13..255)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-low reset
cfg_key  in  128  key value to store
cfg_key_we  in  1  key write strobe
s_valid  in  1  input word valid
s_ready  out  1  input word accepted
s_data  in  32  plaintext word; first word = block bits [127:96]
m_valid  out  1  output word valid
m_ready  in  1  output word accepted
m_data  out  32  ciphertext word; first word = block bits [127:96]
m_last  out  1  marks 4th word of a block
aes_ld  out  1  load pulse to core
aes_key  out  128  key to core
aes_text_in  out  128  plaintext to core
aes_done  in  1  core completion
aes_text_out  in  128  core ciphertext
busy  out  1  high in LOAD/WAIT/DRAIN
err  out  2  sticky: [0] timeout, [1] key write dropped
err_clr  in  1  clears err (both bits)

Behaviour:
- Reset (rst=0, async): state=COLLECT, word count=0, key/text/out registers=0, timer=0; s_ready=0 during reset then 1 in COLLECT; m_valid=0, m_last=0, m_data=0, aes_ld=0, aes_key=0, aes_text_in=0, busy=0, err=0.
- FSM states: COLLECT, LOAD, WAIT, DRAIN.
- COLLECT: s_ready=1. Each s_valid&s_ready shifts s_data into text reg (first word lands in [127:96] after 4 shifts), count++. On 4th handshake: count->0, next state LOAD. Partial blocks held indefinitely.
- LOAD: exactly one cycle, aes_ld=1. aes_key/aes_text_in registered outputs, stable from LOAD through end of WAIT. aes_done during LOAD ignored. Next WAIT, timer cleared.
- WAIT: timer increments each cycle. aes_done=1 -> capture aes_text_out into out reg, next DRAIN (same-cycle done and timer==TIMEOUT_CYC: done wins). Timer reaches TIMEOUT_CYC with no done -> err[0]=1, block discarded, next COLLECT.
- DRAIN: m_valid=1, m_data = out[127:96], then [95:64], [63:32], [31:0] on successive handshakes; m_last=1 only on 4th word. m_data/m_last stable while m_valid&!m_ready. After 4th handshake: m_valid=0 next cycle, next COLLECT. s_ready=0 in LOAD/WAIT/DRAIN (no overlap).
- Key: cfg_key_we in COLLECT or DRAIN -> key reg = cfg_key next edge; takes effect for the next LOAD. cfg_key_we in LOAD or WAIT -> write dropped, err[1]=1.
- err: bits set-sticky; err_clr clears both; same-cycle set and clr -> set wins.
- busy = (state != COLLECT).
- Reset mid-operation: all state abandoned immediately, returns to reset values; aes_ld deasserts asynchronously.
- Latency: 4th input handshake -> aes_ld next cycle; aes_done -> m_valid next cycle.

Test Plan:
- FIPS-197 vector: cfg_key=000102030405060708090a0b0c0d0e0f, words 00112233,44556677,8899aabb,ccddeeff, m_ready=1 -> one aes_ld pulse; out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, m_last on 4th only; err=0.
- Backpressure: same vector, m_ready toggled 1-in-3 -> identical word order, m_data stable while stalled, s_ready=0 until last word accepted.
- Gapped input: s_valid with random gaps, 3 words then 20 idle cycles then 4th -> no aes_ld until 4th handshake, then exactly one.
- Timeout: stub core with aes_done tied 0, TIMEOUT_CYC=31 -> err[0]=1 after 31 WAIT cycles, no m_valid, s_ready=1 next cycle; err_clr -> err=0.
- Key write in WAIT: cfg_key_we pulse mid-WAIT -> err[1]=1, aes_key unchanged, ciphertext matches original key; write in COLLECT -> next block uses new key.
- Reset mid-DRAIN after 2 output words: rst=0 -> m_valid=0, busy=0, count=0; next full block processed correctly.
